// File: rtl/ann_pkg.sv
// Shared definitions for the perceptron layer scheduler.
//   DWIDTH_DEFAULT / FRAC_DEFAULT : default word width and fractional bits
//   ONE                           : fixed-point 1.0 at the default format
//   sched_state_t                 : scheduler FSM states
package ann_pkg;
  localparam int unsigned DWIDTH_DEFAULT = 32;
  localparam int unsigned FRAC_DEFAULT   = 24;
  localparam int          ONE            = 1 << FRAC_DEFAULT;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;
endpackage

// File: rtl/sched_issue_pipe.sv
// LAT-deep (valid, index) shift register that travels alongside the shared
// perceptron datapath, so each result can be matched to its neuron index.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears all stages)
//   i_valid, i_idx    issue strobe and neuron index entering the pipe
//   o_valid, o_idx    tail of the pipe, aligned with dp_result
module sched_issue_pipe
  import ann_pkg::*;
#(
  parameter int unsigned LAT = 1,
  parameter int unsigned IW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [IW-1:0] i_idx,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);
  logic [LAT-1:0] r_valid;
  logic [IW-1:0]  r_idx [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < LAT; i++) r_idx[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_idx[0]   <= i_idx;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_idx[i]   <= r_idx[i-1];
      end
    end
  end

  assign o_valid = r_valid[LAT-1];
  assign o_idx   = r_idx[LAT-1];
endmodule

// File: rtl/perceptron_layer_sched.sv
// Time-multiplexing scheduler: evaluates NEURONS three-input perceptrons on
// one shared datapath, then presents the whole layer result.
// Optional feature macro: LAYER_SCHED_ARGMAX_EN (adds out_class argmax port).
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          input vector handshake; in_a/in_b/in_c vector
//   dp_a/dp_b/dp_c             latched vector to the datapath
//   dp_sel, dp_issue           neuron index (weight/bias address) and issue strobe
//   dp_result                  registered datapath output (LAT cycles after issue)
//   out_valid/out_ready        layer result handshake; out_data packed results
//   busy                       FSM not in IDLE
//   out_class                  argmax neuron index (LAYER_SCHED_ARGMAX_EN only)
module perceptron_layer_sched
  import ann_pkg::*;
#(
  parameter  int unsigned DWIDTH  = DWIDTH_DEFAULT,
  parameter  int unsigned FRAC    = FRAC_DEFAULT,
  parameter  int unsigned NEURONS = 4,
  parameter  int unsigned LAT     = 1,
  localparam int unsigned IW      = $clog2(NEURONS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DWIDTH-1:0]         in_a,
  input  logic [DWIDTH-1:0]         in_b,
  input  logic [DWIDTH-1:0]         in_c,
  output logic [DWIDTH-1:0]         dp_a,
  output logic [DWIDTH-1:0]         dp_b,
  output logic [DWIDTH-1:0]         dp_c,
  output logic [IW-1:0]             dp_sel,
  output logic                      dp_issue,
  input  logic [DWIDTH-1:0]         dp_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NEURONS*DWIDTH-1:0] out_data,
  output logic                      busy
`ifdef LAYER_SCHED_ARGMAX_EN
  ,
  output logic [IW-1:0]             out_class
`endif
);
  if (NEURONS < 2 || NEURONS > 16) begin : g_chk_n
    $error("NEURONS out of range 2..16");
  end
  if (LAT < 1 || LAT > 4) begin : g_chk_lat
    $error("LAT out of range 1..4");
  end
  if (FRAC >= DWIDTH) begin : g_chk_frac
    $error("FRAC must be smaller than DWIDTH");
  end

  localparam logic [IW-1:0] LAST = IW'(NEURONS - 1);

  sched_state_t              r_state, w_next;
  logic [IW-1:0]             r_idx;
  logic [DWIDTH-1:0]         r_a, r_b, r_c;
  logic [NEURONS*DWIDTH-1:0] r_buf;
  logic                      w_tail_valid;
  logic [IW-1:0]             w_tail_idx;
  logic                      w_accept;

  assign w_accept = in_valid && (r_state == IDLE);

  sched_issue_pipe #(.LAT(LAT), .IW(IW)) u_issue_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (dp_issue),
    .i_idx   (r_idx),
    .o_valid (w_tail_valid),
    .o_idx   (w_tail_idx)
  );

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    dp_issue  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        dp_issue = 1'b1;
        if (r_idx == LAST) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_tail_valid && w_tail_idx == LAST) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx <= '0;
        r_a   <= in_a;
        r_b   <= in_b;
        r_c   <= in_c;
      end else if (r_state == RUN && r_idx != LAST) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_tail_valid) r_buf[w_tail_idx*DWIDTH +: DWIDTH] <= dp_result;
    end
  end

`ifdef LAYER_SCHED_ARGMAX_EN
  logic [DWIDTH-1:0] r_max;
  logic [IW-1:0]     r_cls;

  // Strict compare keeps the earliest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max <= '0;
      r_cls <= '0;
    end else if (w_tail_valid &&
                 (w_tail_idx == '0 || $signed(dp_result) > $signed(r_max))) begin
      r_max <= dp_result;
      r_cls <= w_tail_idx;
    end
  end

  assign out_class = r_cls;
`endif

  assign dp_a     = r_a;
  assign dp_b     = r_b;
  assign dp_c     = r_c;
  assign dp_sel   = r_idx;
  assign out_data = r_buf;
endmodule

// File: tb/tb_perceptron_layer_sched.sv
// Self-checking bench: two scheduler instances (NEURONS=4/LAT=1 and
// NEURONS=8/LAT=3), each driven by a stub datapath producing
// dp_a + dp_sel*ONE (or a table value) registered LAT times.
module tb_perceptron_layer_sched;
  import ann_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- instance 0: NEURONS=4, LAT=1 ----------------
  logic        v0 = 1'b0, rdy0, iss0, ov0, ordy0 = 1'b0, busy0;
  logic [31:0] a0 = '0, b0 = '0, c0 = '0, dpa0, dpb0, dpc0, res0;
  logic [1:0]  sel0;
  logic [127:0] od0;
  logic        use_tbl = 1'b0;
  int          tbl [4];
`ifdef LAYER_SCHED_ARGMAX_EN
  logic [1:0]  cls0;
`endif

  perceptron_layer_sched #(.DWIDTH(32), .FRAC(24), .NEURONS(4), .LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0),
    .in_a(a0), .in_b(b0), .in_c(c0), .dp_a(dpa0), .dp_b(dpb0), .dp_c(dpc0),
    .dp_sel(sel0), .dp_issue(iss0), .dp_result(res0),
    .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .busy(busy0)
`ifdef LAYER_SCHED_ARGMAX_EN
    , .out_class(cls0)
`endif
  );

  always @(posedge clk or posedge rst)
    if (rst) res0 <= '0;
    else     res0 <= use_tbl ? 32'(tbl[sel0] * ONE) : dpa0 + 32'(sel0) * 32'(ONE);

  // ---------------- instance 1: NEURONS=8, LAT=3 ----------------
  logic        v1 = 1'b0, rdy1, iss1, ov1, ordy1 = 1'b0, busy1;
  logic [31:0] a1 = '0, b1 = '0, c1 = '0, dpa1, dpb1, dpc1, res1, p1a, p1b;
  logic [2:0]  sel1;
  logic [255:0] od1;
`ifdef LAYER_SCHED_ARGMAX_EN
  logic [2:0]  cls1;
`endif

  perceptron_layer_sched #(.DWIDTH(32), .FRAC(24), .NEURONS(8), .LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
    .in_a(a1), .in_b(b1), .in_c(c1), .dp_a(dpa1), .dp_b(dpb1), .dp_c(dpc1),
    .dp_sel(sel1), .dp_issue(iss1), .dp_result(res1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .busy(busy1)
`ifdef LAYER_SCHED_ARGMAX_EN
    , .out_class(cls1)
`endif
  );

  always @(posedge clk or posedge rst)
    if (rst) begin p1a <= '0; p1b <= '0; res1 <= '0; end
    else begin
      p1a  <= dpa1 + 32'(sel1) * 32'(ONE);
      p1b  <= p1a;
      res1 <= p1b;
    end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Accepts one vector on instance 0 and waits (bounded) for out_valid.
  // lat = cycles from accept to first out_valid, -1 on timeout.
  task automatic do_start0(input logic [31:0] a, output int lat, output int nissue,
                           output bit stable);
    logic [31:0] b, c;
    int t0;
    b = $urandom; c = $urandom;
    a0 = a; b0 = b; c0 = c; v0 = 1'b1; t0 = cyc;
    tick();
    v0 = 1'b0; a0 = $urandom;
    lat = -1; nissue = 0; stable = 1'b1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      if (iss0) nissue++;
      if (dpa0 !== a || dpb0 !== b || dpc0 !== c) stable = 1'b0;
      if (ov0) lat = cyc - t0;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    n_run++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", rdy0); end
    n_run++; if ({iss0, ov0, busy0} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got %b want 000", {iss0, ov0, busy0}); end
    n_run++; if ({sel0, dpa0, dpb0, dpc0} !== '0) begin n_fail++; $display("FAIL reset_dp got %h want 0", {sel0, dpa0, dpb0, dpc0}); end
    n_run++; if (od0 !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", od0); end
    n_run++; if ({rdy1, iss1, ov1, busy1} !== 4'b1000) begin n_fail++; $display("FAIL reset_inst1 got %b want 1000", {rdy1, iss1, ov1, busy1}); end
`ifdef LAYER_SCHED_ARGMAX_EN
    n_run++; if (cls0 !== '0) begin n_fail++; $display("FAIL reset_class got %0d want 0", cls0); end
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int lat, ni; bit st;
    logic [31:0] a;
    a = 32'h0100_0000;
    do_start0(a, lat, ni, st);
    n_run++; if (lat !== 6) begin n_fail++; $display("FAIL single_latency got %0d want 6", lat); end
    n_run++; if (ni !== 4) begin n_fail++; $display("FAIL single_issue_count got %0d want 4", ni); end
    n_run++; if (st !== 1'b1) begin n_fail++; $display("FAIL single_dp_hold got %b want 1", st); end
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if (od0[k*32 +: 32] !== a + 32'(k * ONE)) begin
        n_fail++; $display("FAIL single_slot%0d got %h want %h", k, od0[k*32 +: 32], a + 32'(k * ONE));
      end
    end
    ordy0 = 1'b1; tick(); ordy0 = 1'b0;
    n_run++; if ({rdy0, ov0} !== 2'b10) begin n_fail++; $display("FAIL single_release got %b want 10", {rdy0, ov0}); end
  endtask

  task automatic test_random();
    int lat, ni, hold; bit st;
    logic [31:0] a;
    for (int v = 0; v < 4; v++) begin
      a = $urandom;
      hold = $urandom_range(0, 3);
      do_start0(a, lat, ni, st);
      n_run++; if (lat !== 6) begin n_fail++; $display("FAIL rand%0d_latency got %0d want 6", v, lat); end
      for (int k = 0; k < 4; k++) begin
        n_run++;
        if (od0[k*32 +: 32] !== a + 32'(k * ONE)) begin
          n_fail++; $display("FAIL rand%0d_slot%0d got %h want %h", v, k, od0[k*32 +: 32], a + 32'(k * ONE));
        end
      end
      for (int h = 0; h < hold; h++) tick();
      ordy0 = 1'b1; tick(); ordy0 = 1'b0;
      n_run++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL rand%0d_ready got %b want 1", v, rdy0); end
    end
  endtask

  task automatic test_backpressure();
    int lat, ni; bit st;
    logic [127:0] snap;
    logic [31:0] a;
    int bad;
    a = $urandom;
    do_start0(a, lat, ni, st);
    n_run++; if (lat !== 6) begin n_fail++; $display("FAIL bp_latency got %0d want 6", lat); end
    snap = od0;
    bad = 0;
    for (int h = 0; h < 10; h++) begin
      tick();
      if (od0 !== snap || rdy0 !== 1'b0 || ov0 !== 1'b1) bad++;
    end
    n_run++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    n_run++; if (snap[0 +: 32] !== a) begin n_fail++; $display("FAIL bp_slot0 got %h want %h", snap[0 +: 32], a); end
    ordy0 = 1'b1; tick(); ordy0 = 1'b0;
    n_run++; if ({rdy0, ov0} !== 2'b10) begin n_fail++; $display("FAIL bp_release got %b want 10", {rdy0, ov0}); end
  endtask

  task automatic test_ignore_in_run();
    logic [31:0] a, a2;
    int t0, lat;
    bit held;
    a = $urandom; a2 = ~a;
    a0 = a; v0 = 1'b1; t0 = cyc; tick();
    a0 = a2;
    n_run++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL ign_ready got %b want 0", rdy0); end
    tick(); v0 = 1'b0;
    lat = -1; held = 1'b1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      if (dpa0 !== a) held = 1'b0;
      if (ov0) lat = cyc - t0; else tick();
    end
    n_run++; if (lat !== 6) begin n_fail++; $display("FAIL ign_latency got %0d want 6", lat); end
    n_run++; if (held !== 1'b1) begin n_fail++; $display("FAIL ign_dp_a got %h want %h", dpa0, a); end
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if (od0[k*32 +: 32] !== a + 32'(k * ONE)) begin
        n_fail++; $display("FAIL ign_slot%0d got %h want %h", k, od0[k*32 +: 32], a + 32'(k * ONE));
      end
    end
    ordy0 = 1'b1; tick(); ordy0 = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat, ni, bad; bit st;
    logic [31:0] a;
    a0 = $urandom; v0 = 1'b1; tick(); v0 = 1'b0;   // now cycle T+1
    tick(); tick();                                 // now cycle T+3
    rst = 1'b1; #1;
    n_run++; if ({iss0, busy0, ov0, rdy0} !== 4'b0001) begin n_fail++; $display("FAIL rst_run_ctrl got %b want 0001", {iss0, busy0, ov0, rdy0}); end
    n_run++; if ({sel0, dpa0, dpb0, dpc0} !== '0) begin n_fail++; $display("FAIL rst_run_dp got %h want 0", {sel0, dpa0, dpb0, dpc0}); end
    n_run++; if (od0 !== '0) begin n_fail++; $display("FAIL rst_run_data got %h want 0", od0); end
    tick(); rst = 1'b0;
    bad = 0;
    for (int h = 0; h < 10; h++) begin
      tick();
      if (ov0 !== 1'b0 || od0 !== '0 || busy0 !== 1'b0) bad++;
    end
    n_run++; if (bad !== 0) begin n_fail++; $display("FAIL rst_run_quiet got %0d bad cycles want 0", bad); end
    a = $urandom;
    do_start0(a, lat, ni, st);
    n_run++; if (lat !== 6) begin n_fail++; $display("FAIL rst_run_restart_latency got %0d want 6", lat); end
    n_run++; if (od0[96 +: 32] !== a + 32'(3 * ONE)) begin n_fail++; $display("FAIL rst_run_restart_slot3 got %h want %h", od0[96 +: 32], a + 32'(3 * ONE)); end
    ordy0 = 1'b1; tick(); ordy0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] acc_a;
    int acc_t, last_ov, ndone;
    bit have_ov, accepted;
    ordy1 = 1'b1; v1 = 1'b1; a1 = $urandom;
    acc_t = -100; last_ov = 0; ndone = 0; have_ov = 1'b0; acc_a = '0;
    for (int i = 0; i < 200 && ndone < 4; i++) begin
      accepted = 1'b0;
      if (rdy1) begin
        if (have_ov) begin
          n_run++; if (cyc - last_ov !== 1) begin n_fail++; $display("FAIL b2b_accept_gap got %0d want 1", cyc - last_ov); end
        end
        acc_t = cyc; acc_a = a1; accepted = 1'b1;
      end
      if (ov1) begin
        n_run++; if (cyc - acc_t !== 12) begin n_fail++; $display("FAIL b2b_latency got %0d want 12", cyc - acc_t); end
        for (int k = 0; k < 8; k++) begin
          n_run++;
          if (od1[k*32 +: 32] !== acc_a + 32'(k * ONE)) begin
            n_fail++; $display("FAIL b2b_slot%0d got %h want %h", k, od1[k*32 +: 32], acc_a + 32'(k * ONE));
          end
        end
        last_ov = cyc; have_ov = 1'b1; ndone++;
        if (ndone == 4) v1 = 1'b0;
      end
      tick();
      if (accepted) a1 = $urandom;
    end
    n_run++; if (ndone !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", ndone); end
    ordy1 = 1'b0;
    tick();
  endtask

`ifdef LAYER_SCHED_ARGMAX_EN
  task automatic test_argmax();
    int lat, ni, best; bit st;
    int sets [3][4];
    sets[0] = '{5, 9, 9, 2};
    sets[1] = '{-3, -1, -1, -7};
    for (int k = 0; k < 4; k++) sets[2][k] = $urandom_range(0, 20) - 10;
    use_tbl = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tbl = sets[s];
      best = 0;
      for (int k = 1; k < 4; k++) if (sets[s][k] > sets[s][best]) best = k;
      do_start0($urandom, lat, ni, st);
      n_run++; if (lat !== 6) begin n_fail++; $display("FAIL argmax%0d_latency got %0d want 6", s, lat); end
      n_run++; if (cls0 !== 2'(best)) begin n_fail++; $display("FAIL argmax%0d_class got %0d want %0d", s, cls0, best); end
      ordy0 = 1'b1; tick(); ordy0 = 1'b0;
    end
    use_tbl = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_random();
    test_backpressure();
    test_ignore_in_run();
    test_reset_mid_run();
    test_back_to_back();
`ifdef LAYER_SCHED_ARGMAX_EN
    test_argmax();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/perceptron_layer_sched.md
# perceptron_layer_sched

Time-multiplexing scheduler that evaluates a full layer of NEURONS three-input perceptrons on one shared perceptron datapath. It accepts one input vector (A, B, C) per handshake and latches it. It then issues neuron indices to the datapath on consecutive cycles; the weight/bias memory is indexed by `dp_sel`. It captures the registered sigmoid results into an output buffer and presents the whole layer result with a valid/ready handshake to the next layer.

## Interface
- `DWIDTH`, 32: data word width, signed fixed point.
- `FRAC`, 24: fractional bits, Q(DWIDTH-FRAC).FRAC.
- `NEURONS`, 4: neurons per layer, range 2..16.
- `LAT`, 1: datapath latency in cycles, from `dp_sel`/`dp_*` inputs to `dp_result`, range 1..4.
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  scheduler can accept a vector.
- `in_a`, `in_b`, `in_c`  in  DWIDTH each  input vector.
- `dp_a`, `dp_b`, `dp_c`  out  DWIDTH each  latched vector to the datapath.
- `dp_sel`  out  IW=$clog2(NEURONS)  neuron index, which addresses the weight/bias memory.
- `dp_issue`  out  1  a neuron is issued this cycle.
- `dp_result`  in  DWIDTH  registered datapath output.
- `out_valid`  out  1  layer result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  NEURONS*DWIDTH  results; neuron k occupies bits [k*DWIDTH +: DWIDTH].
- `busy`  out  1  high in any state other than IDLE.
- `out_class`  out  IW  argmax index; present only with `LAYER_SCHED_ARGMAX_EN`.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `in_a`/`in_b`/`in_c` into `dp_a`/`dp_b`/`dp_c`, set issue index to 0, go to RUN.
- RUN:
  - `dp_issue`=1 and `dp_sel`=issue index; the index increments every cycle.
  - After issuing NEURONS-1, go to DRAIN.
  - `dp_a`/`dp_b`/`dp_c` are held constant from acceptance until DONE exits.
- Issue tracker:
  - A LAT-deep shift register carries (valid, index) alongside the datapath.
  - When its tail is valid, `dp_result` is written to buffer slot = tail index in that same cycle.
- DRAIN:
  - `dp_issue`=0 and `dp_sel` holds the last index.
  - When the capture of index NEURONS-1 occurs, go to DONE.
- DONE:
  - `out_valid`=1; `out_data` and `out_class` are stable.
  - On `out_ready`, go to IDLE. `out_valid` drops the next cycle.
  - `out_valid` never deasserts without `out_ready`.
- No new vector is accepted outside IDLE; `in_ready`=0 in RUN, DRAIN and DONE.
- `in_valid` without `in_ready` is ignored and no state changes.
- Buffer slots not yet written in the current pass keep their previous pass values. All slots are overwritten before DONE.
- Reset (asynchronous, any state, including mid-RUN or DRAIN):
  - State goes to IDLE; index and tracker are cleared.
  - `in_ready`=1; `dp_issue`=0, `out_valid`=0, `busy`=0.
  - `dp_sel`=0, `dp_a`/`dp_b`/`dp_c`=0, `out_data`=0, `out_class`=0.
  - The datapath shares `rst`, so no stale capture follows reset.

## Timing
- Accept at cycle T.
- Neuron k is issued in cycle T+1+k and captured in cycle T+1+k+LAT.
- `out_valid` is first high in cycle T+2+NEURONS-1+LAT = T+NEURONS+LAT+1. For the defaults this is T+6.
- `in_ready` rises the cycle after the `out_valid`&&`out_ready` handshake. Throughput is one vector per NEURONS+LAT+2 cycles with `out_ready` held at 1.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only; there is no combinational path from `in_valid` or `out_ready`.

## Configuration
- `LAYER_SCHED_ARGMAX_EN` defined:
  - Add port `out_class` and a running max register (DWIDTH, signed) plus index, both updated on each capture.
  - Capture of index 0 loads the max unconditionally.
  - Later captures replace the max only if strictly greater, so ties resolve to the lowest index.
  - `out_class` is valid with `out_valid`.
- Not defined: the `out_class` port, max register and comparator are absent; all other behaviour is identical.

## Structure
- Shared package `ann_pkg` holds:
  - `DWIDTH`/`FRAC` defaults.
  - The state enum `sched_state_t` {IDLE, RUN, DRAIN, DONE}.
  - The fixed-point constant ONE = 1<<FRAC.
- Sub-module `sched_issue_pipe` is the LAT-deep (valid, index) shift register, cleared by `rst`.

## Test plan
All scenarios use a bench stub datapath: `dp_result` = (`dp_a` + `dp_sel`·ONE), registered LAT times.
- Single vector, NEURONS=4, LAT=1, `in_a`=32'h0100_0000:
  - Expect `out_valid` at T+6.
  - Expect slots = 0x0100_0000, 0x0200_0000, 0x0300_0000, 0x0400_0000.
  - Expect `dp_issue` high exactly 4 cycles.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE, then pulse to 1.
  - `out_data` stays stable and `in_ready` stays 0 throughout.
  - `in_ready`=1 the cycle after the handshake.
- `in_valid` pulsed during RUN with a different `in_a`:
  - It is ignored; `dp_a` is unchanged and the results match the first vector.
- Reset asserted in cycle T+3 (mid-RUN):
  - In the same cycle `dp_issue`=0 and `busy`=0.
  - Every output takes its reset value; no capture or `out_valid` follows.
  - A new vector accepted after reset completes normally.
- LAT=3, NEURONS=8, back-to-back vectors with `out_ready`=1:
  - `out_valid` at T+12.
  - The next accept is at T+13, one cycle after the handshake.
- With `LAYER_SCHED_ARGMAX_EN`, stub `dp_result` sequence 5, 9, 9, 2 (×ONE):
  - Expect `out_class`=1.
  - With sequence −3, −1, −1, −7, expect `out_class`=1.
